// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Holds the FSM state encoding and the default ARM wait length.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ARM,
    S_STALL,
    S_HALTED
  } state_t;

  localparam int ARM_TIMEOUT_DEFAULT = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/delay bus between the PC sequencer (master) and its environment
// (instruction memory plus delay counter).
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 16
);
  logic                pc_en;
  logic                delay_req;
  logic                fetch_req;
  logic                fetch_ack;
  logic [PC_WIDTH-1:0] pc;
  logic                is_delay;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                halt;
  logic                halted;

  modport master (
    input  pc_en, fetch_ack, is_delay, redirect_valid, redirect_target, halt,
    output delay_req, fetch_req, pc, halted
  );

  modport slave (
    output pc_en, fetch_ack, is_delay, redirect_valid, redirect_target, halt,
    input  delay_req, fetch_req, pc, halted
  );
endinterface

// File: rtl/pc_sequencer_arm_timer.sv
// Down-counter bounding how long ARM waits for pc_en to fall.
// Expires on the last permitted ARM cycle so the FSM leaves ARM exactly on time.
module arm_timer #(
  parameter int ARM_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  localparam int TW = $clog2(ARM_TIMEOUT + 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= TW'(ARM_TIMEOUT);
    end else if (i_count && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_expire = (r_count == TW'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetches, follows redirects, arms the
// external delay counter on delay instructions and stops on halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                ARM_TIMEOUT  = ARM_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus
);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_fetch_req;
  logic                r_delay_req;
  logic                r_halted;

  logic                w_ack;
  logic                w_timer_load;
  logic                w_timer_count;
  logic                w_timer_expire;
  logic [PC_WIDTH-1:0] w_next_pc;

  // An ack only counts against a request actually on the bus.
  assign w_ack         = (r_state == S_FETCH) && r_fetch_req && bus.fetch_ack;
  assign w_next_pc     = bus.redirect_valid ? bus.redirect_target : (r_pc + PC_WIDTH'(1));
  assign w_timer_load  = w_ack && !bus.halt && bus.is_delay;
  assign w_timer_count = (r_state == S_ARM) && bus.pc_en;

  arm_timer #(
    .ARM_TIMEOUT (ARM_TIMEOUT)
  ) u_arm_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_timer_load),
    .i_count  (w_timer_count),
    .o_expire (w_timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VECTOR;
      r_fetch_req <= 1'b0;
      r_delay_req <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_delay_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state     <= S_FETCH;
          r_fetch_req <= bus.pc_en;
        end
        S_FETCH: begin
          if (w_ack && bus.halt) begin
            r_state     <= S_HALTED;
            r_halted    <= 1'b1;
            r_fetch_req <= 1'b0;
          end else if (w_ack && bus.is_delay) begin
            r_pc        <= w_next_pc;
            r_state     <= S_ARM;
            r_delay_req <= 1'b1;
            r_fetch_req <= 1'b0;
          end else begin
            if (w_ack) begin
              r_pc <= w_next_pc;
            end
            r_fetch_req <= bus.pc_en;
          end
        end
        S_ARM: begin
          if (!bus.pc_en) begin
            r_state <= S_STALL;
          end else if (w_timer_expire) begin
            // Delay counter never dropped pc_en: treat as zero-length delay.
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        S_STALL: begin
          if (bus.pc_en) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        S_HALTED: begin
          r_fetch_req <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_fetch_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.fetch_req = r_fetch_req;
  assign bus.delay_req = r_delay_req;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, advance, redirect/wrap, delay
// stall, zero-length delay, halt priority and asynchronous reset recovery.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pc_sequencer_if #(.PC_WIDTH(16)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (16),
    .RESET_VECTOR (16'h0000),
    .ARM_TIMEOUT  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n                = 1'b0;
    bus.pc_en            = 1'b1;
    bus.fetch_ack        = 1'b0;
    bus.is_delay         = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_target  = 16'h0000;
    bus.halt             = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_pc",        32'(bus.pc),        32'h0);
    chk("rst_fetch_req", 32'(bus.fetch_req), 32'h0);
    chk("rst_delay_req", 32'(bus.delay_req), 32'h0);
    chk("rst_halted",    32'(bus.halted),    32'h0);

    // Release: one IDLE cycle, then fetch at pc=0 with immediate acks
    rst_n = 1'b1;
    #1 chk("idle_no_req", 32'(bus.fetch_req), 32'h0);
    tick();
    chk("first_req", 32'(bus.fetch_req), 32'h1);
    chk("seq_pc0",   32'(bus.pc),        32'h0);
    bus.fetch_ack = 1'b1;
    tick(); chk("seq_pc1", 32'(bus.pc), 32'h1);
    tick(); chk("seq_pc2", 32'(bus.pc), 32'h2);
    tick(); chk("seq_pc3", 32'(bus.pc), 32'h3);
    tick(); tick();
    chk("seq_pc5", 32'(bus.pc), 32'h5);

    // Redirect and wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0040;
    tick(); chk("redirect_40", 32'(bus.pc), 32'h40);
    bus.redirect_target = 16'hFFFF;
    tick(); chk("redirect_ffff", 32'(bus.pc), 32'hFFFF);
    bus.redirect_valid = 1'b0;
    tick(); chk("wrap_0", 32'(bus.pc), 32'h0);
    chk("wrap_req", 32'(bus.fetch_req), 32'h1);

    // Delay instruction at pc=3 followed by a 10-cycle stall
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0003;
    tick(); chk("redirect_3", 32'(bus.pc), 32'h3);
    bus.redirect_valid = 1'b0;
    bus.is_delay       = 1'b1;
    tick();
    chk("delay_pc4",   32'(bus.pc),        32'h4);
    chk("delay_pulse", 32'(bus.delay_req), 32'h1);
    chk("arm_no_req",  32'(bus.fetch_req), 32'h0);
    bus.fetch_ack = 1'b0;
    bus.is_delay  = 1'b0;
    bus.pc_en     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_no_req",   32'(bus.fetch_req), 32'h0);
      chk("stall_no_delay", 32'(bus.delay_req), 32'h0);
    end
    bus.pc_en = 1'b1;
    tick();
    chk("resume_req", 32'(bus.fetch_req), 32'h1);
    chk("resume_pc4", 32'(bus.pc),        32'h4);

    // Zero-length delay: pc_en stays 1, ARM lasts exactly 4 cycles
    bus.fetch_ack = 1'b1;
    bus.is_delay  = 1'b1;
    tick();
    chk("zl_delay_pulse", 32'(bus.delay_req), 32'h1);
    chk("zl_pc5",         32'(bus.pc),        32'h5);
    bus.fetch_ack = 1'b0;
    bus.is_delay  = 1'b0;
    tick(); chk("zl_arm2_req",   32'(bus.fetch_req), 32'h0);
    chk("zl_arm2_delay", 32'(bus.delay_req), 32'h0);
    tick(); chk("zl_arm3_req", 32'(bus.fetch_req), 32'h0);
    tick(); chk("zl_arm4_req", 32'(bus.fetch_req), 32'h0);
    tick(); chk("zl_fetch_req", 32'(bus.fetch_req), 32'h1);
    chk("zl_fetch_pc", 32'(bus.pc), 32'h5);

    // Halt has priority over is_delay at pc=7
    bus.fetch_ack = 1'b1;
    tick(); tick();
    chk("pre_halt_pc7", 32'(bus.pc), 32'h7);
    bus.halt     = 1'b1;
    bus.is_delay = 1'b1;
    tick();
    chk("halted",          32'(bus.halted),    32'h1);
    chk("halt_pc7",        32'(bus.pc),        32'h7);
    chk("halt_no_delay",   32'(bus.delay_req), 32'h0);
    bus.halt     = 1'b0;
    bus.is_delay = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_no_req", 32'(bus.fetch_req), 32'h0);
    end
    chk("halt_pc_hold",     32'(bus.pc),     32'h7);
    chk("halt_still",       32'(bus.halted), 32'h1);
    chk("halt_no_delay2",   32'(bus.delay_req), 32'h0);

    // Reset out of HALTED
    bus.fetch_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("hrst_halted", 32'(bus.halted), 32'h0);
    chk("hrst_pc", 32'(bus.pc), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("hrst_req", 32'(bus.fetch_req), 32'h1);

    // Reset during STALL
    bus.fetch_ack = 1'b1;
    bus.is_delay  = 1'b1;
    tick(); chk("srst_pc1", 32'(bus.pc), 32'h1);
    bus.fetch_ack = 1'b0;
    bus.is_delay  = 1'b0;
    bus.pc_en     = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk("srst_pc",    32'(bus.pc),        32'h0);
    chk("srst_req",      32'(bus.fetch_req), 32'h0);
    chk("srst_delay",    32'(bus.delay_req), 32'h0);
    bus.pc_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("srst_first_req", 32'(bus.fetch_req), 32'h1);
    chk("srst_first_pc",  32'(bus.pc),        32'h0);

    // Reset during a pending fetch_req
    bus.fetch_ack = 1'b1;
    tick(); tick();
    bus.fetch_ack = 1'b0;
    tick();
    chk("pend_hold_pc",  32'(bus.pc),        32'h2);
    chk("pend_hold_req", 32'(bus.fetch_req), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("prst_req", 32'(bus.fetch_req), 32'h0);
    chk("prst_pc", 32'(bus.pc), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("prst_first_req", 32'(bus.fetch_req), 32'h1);
    chk("prst_first_pc",  32'(bus.pc),        32'h0);

    // Ack while fetch_req=0 is ignored
    bus.pc_en = 1'b0;
    tick(); chk("noreq_req", 32'(bus.fetch_req), 32'h0);
    bus.fetch_ack = 1'b1;
    tick();
    chk("noreq_ack_pc", 32'(bus.pc), 32'h0);
    chk("noreq_ack_req", 32'(bus.fetch_req), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
